// File: rtl/barrel_unrotate_pipe.sv
// Four-stage inverse barrel rotator: undoes an upstream rotate of a 16-bit word,
// one amount bit per stage, with a valid/ready chain that lets bubbles compress.
module barrel_unrotate_pipe (
  input  logic        clk,
  input  logic        reset,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [15:0] in_num,
  input  logic [3:0]  in_amt,
  input  logic        in_lr,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [15:0] out_num,
  output logic        busy
);
  localparam int DATA_W = 16;

  // lr=1 means the word was rotated right upstream, so undo it with a left rotate.
  function automatic logic [DATA_W-1:0] unrot_step(input logic [DATA_W-1:0] d,
                                                   input logic en, input logic lr,
                                                   input int sh);
    if (!en)
      return d;
    else if (lr)
      return (d << sh) | (d >> (DATA_W - sh));
    else
      return (d >> sh) | (d << (DATA_W - sh));
  endfunction

  logic              vld_p1, vld_p2, vld_p3, vld_p4;
  logic [DATA_W-1:0] data_p1, data_p2, data_p3, data_p4;
  logic [2:0]        amt_p1;
  logic [1:0]        amt_p2;
  logic              amt_p3;
  logic              dir_p1, dir_p2, dir_p3;
  logic              adv1, adv2, adv3, adv4;

  assign adv4      = out_ready | ~vld_p4;
  assign adv3      = adv4 | ~vld_p3;
  assign adv2      = adv3 | ~vld_p2;
  assign adv1      = adv2 | ~vld_p1;
  assign in_ready  = adv1 & ~reset;
  assign out_valid = vld_p4;
  assign out_num   = data_p4;
  assign busy      = vld_p1 | vld_p2 | vld_p3 | vld_p4;

  always_ff @(posedge clk) begin
    if (reset) begin
      vld_p1  <= 1'b0;
      vld_p2  <= 1'b0;
      vld_p3  <= 1'b0;
      vld_p4  <= 1'b0;
      data_p1 <= '0;
      data_p2 <= '0;
      data_p3 <= '0;
      data_p4 <= '0;
    end else begin
      // stage 1: rotate by 1
      if (adv1) begin
        vld_p1  <= in_valid & in_ready;
        data_p1 <= unrot_step(in_num, in_amt[0], in_lr, 1);
      end
      // stage 2: rotate by 2
      if (adv2) begin
        vld_p2  <= vld_p1;
        data_p2 <= unrot_step(data_p1, amt_p1[0], dir_p1, 2);
      end
      // stage 3: rotate by 4
      if (adv3) begin
        vld_p3  <= vld_p2;
        data_p3 <= unrot_step(data_p2, amt_p2[0], dir_p2, 4);
      end
      // stage 4: rotate by 8
      if (adv4) begin
        vld_p4  <= vld_p3;
        data_p4 <= unrot_step(data_p3, amt_p3, dir_p3, 8);
      end
    end
  end

  // Remaining amount bits and direction need no reset: they only matter alongside a valid bit.
  always_ff @(posedge clk) begin
    if (adv1) begin
      amt_p1 <= in_amt[3:1];
      dir_p1 <= in_lr;
    end
    if (adv2) begin
      amt_p2 <= amt_p1[2:1];
      dir_p2 <= dir_p1;
    end
    if (adv3) begin
      amt_p3 <= amt_p2[1];
      dir_p3 <= dir_p2;
    end
  end

endmodule

// File: tb/tb_barrel_unrotate_pipe.sv
// Self-checking bench for barrel_unrotate_pipe: directed latency/boundary cases,
// streaming, back-pressure, random stalls and mid-stream reset against a scoreboard.
module tb_barrel_unrotate_pipe;
  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] in_num;
  logic [3:0]  in_amt;
  logic        in_lr;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] out_num;
  logic        busy;

  logic [15:0] cur_exp;
  logic [15:0] q[$];
  int          pass_cnt = 0;
  int          total = 0;
  int          n_out = 0;
  logic [15:0] bp_d[6];
  logic [15:0] exp_v;

  barrel_unrotate_pipe dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .in_num(in_num), .in_amt(in_amt), .in_lr(in_lr), .out_valid(out_valid),
    .out_ready(out_ready), .out_num(out_num), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) pass_cnt++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  // Reference forward rotate: what the upstream rotator applied to the original word.
  function automatic logic [15:0] fwd_rot(input logic [15:0] d, input logic [3:0] a, input logic lr);
    logic [31:0] t;
    if (lr) begin
      t = {d, d} >> a;
      return t[15:0];
    end else begin
      t = {d, d} << a;
      return t[31:16];
    end
  endfunction

  // Scoreboard monitor, sampling between active edges.
  always @(negedge clk) begin
    if (reset) begin
      q.delete();
    end else begin
      if (out_valid && out_ready) begin
        n_out++;
        if (q.size() == 0) chk("sb_extra_output", 32'(out_num), 32'hFFFF_FFFF);
        else begin
          exp_v = q.pop_front();
          chk("sb_data", 32'(out_num), 32'(exp_v));
        end
      end
      if (in_valid && in_ready) q.push_back(cur_exp);
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached, checks %0d/%0d", pass_cnt, total);
    $fatal(1, "watchdog");
  end

  task automatic send_lat(input string tag, input logic [15:0] num, input logic [3:0] amt,
                          input logic lr, input logic [15:0] exp);
    @(posedge clk); #1;
    in_valid = 1'b1; in_num = num; in_amt = amt; in_lr = lr; cur_exp = exp;
    @(negedge clk);
    chk({tag, "_in_ready"}, 32'(in_ready), 32'd1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk({tag, "_early"}, 32'(out_valid), 32'd0);
    @(negedge clk);
    chk({tag, "_valid"}, 32'(out_valid), 32'd1);
    chk({tag, "_data"}, 32'(out_num), 32'(exp));
  endtask

  initial begin
    int sent;
    int cyc;
    logic [15:0] d;
    logic [3:0]  a;
    logic        l;
    logic        pending;

    reset = 1'b1; in_valid = 1'b0; in_num = '0; in_amt = '0; in_lr = 1'b0;
    out_ready = 1'b1; cur_exp = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_out_num", 32'(out_num), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_in_ready", 32'(in_ready), 32'd0);
    @(posedge clk); #1;
    reset = 1'b0;
    @(negedge clk);
    chk("post_rst_in_ready", 32'(in_ready), 32'd1);

    send_lat("basic_r", 16'h0002, 4'd1, 1'b0, 16'h0001);
    send_lat("basic_l", 16'h8000, 4'd1, 1'b1, 16'h0001);
    send_lat("amt0", 16'hBEEF, 4'd0, 1'b0, 16'hBEEF);
    send_lat("amt15", 16'h0001, 4'd15, 1'b0, 16'h0002);
    send_lat("amt8", 16'h12AB, 4'd8, 1'b1, 16'hAB12);

    // Streaming: all 32 (amt, lr) combinations back to back.
    for (int i = 0; i < 36; i++) begin
      @(posedge clk); #1;
      if (i < 32) begin
        d = 16'($urandom);
        a = 4'(i % 16);
        l = (i >= 16);
        in_valid = 1'b1; in_num = fwd_rot(d, a, l); in_amt = a; in_lr = l; cur_exp = d;
      end else in_valid = 1'b0;
      @(negedge clk);
      if (i < 32) chk("stream_in_ready", 32'(in_ready), 32'd1);
      if (i >= 4) chk("stream_out_valid", 32'(out_valid), 32'd1);
    end
    @(posedge clk); #1;
    @(negedge clk);
    chk("stream_drained", 32'(q.size()), 32'd0);

    // Back-pressure: 6 words, out_ready low while the first four are held.
    for (int k = 0; k < 6; k++) bp_d[k] = 16'($urandom);
    sent = 0;
    for (cyc = 0; cyc < 30; cyc++) begin
      @(posedge clk); #1;
      out_ready = !(cyc >= 4 && cyc < 9);
      if (sent < 6) begin
        a = 4'($urandom_range(15, 0));
        l = 1'($urandom_range(1, 0));
        in_valid = 1'b1; in_num = fwd_rot(bp_d[sent], a, l); in_amt = a; in_lr = l;
        cur_exp = bp_d[sent];
      end else in_valid = 1'b0;
      @(negedge clk);
      if (cyc >= 4 && cyc < 9) begin
        chk("bp_in_ready_full", 32'(in_ready), 32'd0);
        chk("bp_out_valid", 32'(out_valid), 32'd1);
        chk("bp_out_stable", 32'(out_num), 32'(bp_d[0]));
      end
      if (in_valid && in_ready) sent++;
    end
    chk("bp_sent", 32'(sent), 32'd6);
    chk("bp_drained", 32'(q.size()), 32'd0);

    // Random stalls with the scoreboard checking order and integrity.
    n_out = 0;
    sent = 0;
    pending = 1'b0;
    cyc = 0;
    while (sent < 2000 && cyc < 20000) begin
      @(posedge clk); #1;
      out_ready = 1'($urandom_range(1, 0));
      if (!pending && $urandom_range(99, 0) < 70) begin
        d = 16'($urandom);
        a = 4'($urandom_range(15, 0));
        l = 1'($urandom_range(1, 0));
        in_num = fwd_rot(d, a, l); in_amt = a; in_lr = l; cur_exp = d;
        pending = 1'b1;
      end
      in_valid = pending;
      @(negedge clk);
      if (in_valid && in_ready) begin
        sent++;
        pending = 1'b0;
      end
      cyc++;
    end
    @(posedge clk); #1;
    in_valid = 1'b0; out_ready = 1'b1;
    cyc = 0;
    while (q.size() != 0 && cyc < 100) begin
      @(negedge clk);
      cyc++;
    end
    @(negedge clk);
    chk("rand_sent", 32'(sent), 32'd2000);
    chk("rand_out_count", 32'(n_out), 32'd2000);
    chk("rand_drained", 32'(q.size()), 32'd0);

    // Reset with three words in flight.
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      d = 16'($urandom);
      in_valid = 1'b1; in_num = fwd_rot(d, 4'd3, 1'b0); in_amt = 4'd3; in_lr = 1'b0; cur_exp = d;
    end
    @(posedge clk); #1;
    reset = 1'b1;
    @(negedge clk);
    chk("rst_mid_in_ready", 32'(in_ready), 32'd0);
    @(posedge clk); #1;
    reset = 1'b0; in_valid = 1'b0;
    @(negedge clk);
    chk("rst_mid_out_valid", 32'(out_valid), 32'd0);
    chk("rst_mid_busy", 32'(busy), 32'd0);
    chk("rst_mid_out_num", 32'(out_num), 32'd0);
    chk("rst_mid_in_ready_after", 32'(in_ready), 32'd1);
    n_out = 0;
    repeat (10) @(negedge clk);
    chk("rst_mid_no_flushed_output", 32'(n_out), 32'd0);

    $display("%0d/%0d checks passed", pass_cnt, total);
    $finish;
  end

endmodule
